sfo_peak_search: RTL
====================

// Module: sfo_peak_search
// PURPOSE
//  Sweep controller directly downstream of sfo_fft_correlator. Steps the correlator through N SFO
//  hypotheses (start + k*step, fixed point), pulses correlation_reset and an FFT-replay request per
//  hypothesis, collects correlation_out, and reports the best threshold-passing hypothesis.
//  Result feeds packet timing recovery in axi_mrr_gateway.
// PARAMETERS
//  SFO_INT_WIDTH    9     integer width of SFO hypothesis (matches correlator)
//  SFO_FRAC_WIDTH   16    fractional width of SFO hypothesis
//  CORR_WIDTH       32    correlator output = {meets_threshold, CORR_WIDTH-bit magnitude}
//  HYP_CNT_WIDTH    8     width of hypothesis count/index
//  TIMEOUT_CYCLES   4096  max cycles to wait for correlation_out_valid per hypothesis (>=4)
// PORTS
//  clk                    in   1               clock
//  reset                  in   1               synchronous, active-high
//  start                  in   1               one-cycle pulse; begin sweep (ignored unless IDLE)
//  abort                  in   1               return to IDLE next cycle; no done pulse
//  sfo_start_int/frac     in   INT/FRAC        first hypothesis, sampled on accepted start
//  sfo_step_int/frac      in   INT/FRAC        hypothesis increment, sampled on accepted start
//  num_hypotheses         in   HYP_CNT_WIDTH   sweep length, sampled on accepted start
//  sfo_int_part/frac_part out  INT/FRAC        to correlator; current hypothesis
//  correlation_reset      out  1               to correlator; one-cycle pulse per hypothesis
//  fft_replay_start       out  1               to FFT buffer; one-cycle pulse, same cycle as reset
//  correlation_out        in   CORR_WIDTH+1    from correlator; MSB = meets threshold
//  correlation_out_valid  in   1               from correlator; level, cleared by correlation_reset
//  busy                   out  1               high in every state except IDLE
//  done                   out  1               one-cycle pulse at end of sweep
//  best_valid             out  1               at least one hypothesis passed threshold
//  best_sfo_int/frac      out  INT/FRAC        hypothesis of best_corr
//  best_corr              out  CORR_WIDTH      magnitude of best passing hypothesis
//  best_index             out  HYP_CNT_WIDTH   k of best hypothesis
//  timeout_count          out  HYP_CNT_WIDTH   hypotheses skipped by timeout this sweep
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0. Reset mid-sweep discards everything; no done pulse.
//  - FSM IDLE->LOAD on start: latch config, hyp = start, k=0, clear best_*/timeout_count.
//    num_hypotheses==0: IDLE->DONE directly (done pulses, best_valid=0).
//  - LOAD (1 cycle): correlation_reset=1, fft_replay_start=1, sfo_*_part=hyp (held stable until
//    next LOAD). -> WAIT, wait counter cleared.
//  - WAIT: correlation_out_valid=1 -> UPDATE (sample correlation_out that cycle). Counter reaching
//    TIMEOUT_CYCLES-1 first -> SKIP. Valid and timeout same cycle: valid wins.
//  - UPDATE: if MSB=1 and (!best_valid or mag > best_corr) replace best_*; ties keep earlier k.
//  - SKIP: timeout_count++ (saturates at all-ones).
//  - UPDATE/SKIP: k==num_hypotheses-1 -> DONE; else k++, hyp += step -> LOAD.
//  - Hypothesis add: {int,frac} full-width fixed-point add; frac carry into int; int wraps modulo
//    2^SFO_INT_WIDTH silently.
//  - DONE (1 cycle): done=1 -> IDLE. best_*/timeout_count hold until next accepted start.
//  - Throughput: 3 cycles overhead per hypothesis plus correlator latency.
//  - abort in any state: -> IDLE next cycle, busy=0, no done; best_* hold partial values.
//    abort and start in the same cycle: abort wins. reset overrides both.
// CONFIGURATION
//  SFO_PEAK_SEARCH_SECOND_BEST_EN defined: adds outputs second_corr[CORR_WIDTH], second_valid,
//   second_index; tracks the runner-up passing hypothesis (demoted best moves to second; ties with
//   second keep earlier k). Used for peak-to-sidelobe qualification.
//  Undefined: ports absent, no extra logic; all other behaviour identical.
// TESTING
//  1. start, hyp 10.0, step 0.5 (frac 0x8000), N=4; model returns MSB=1, mags 5,9,9,3 -> sfo_int_part
//     sequence 10,10,11,11 (frac 0,8000,0,8000); best_index=1, best_corr=9, best_valid=1; one done.
//  2. N=3, all MSB=0 -> done pulses, best_valid=0, best_corr=0, timeout_count=0.
//  3. TIMEOUT_CYCLES=16, model never asserts valid for k=1 of N=3 -> SKIP after 16 WAIT cycles,
//     timeout_count=1, sweep completes, 3 correlation_reset pulses.
//  4. hyp int 511 frac 0xC000, step 0.5, N=2 -> second hypothesis int 0 frac 0x4000 (wrap).
//  5. abort during WAIT of k=2 -> busy=0 next cycle, no done; start same cycle as abort ignored;
//     reset mid-LOAD -> all outputs 0.
//  6. SECOND_BEST_EN: mags 4,8,6 all passing -> best 8 (k=1), second 6 (k=2), second_valid=1.

Source files
------------

// File: rtl/sfo_peak_search_if.sv
// Bundle between the SFO sweep controller and its neighbours: sweep control and config,
// the correlator/FFT-replay handshake, and the best-hypothesis result.
// Ports: slave = sfo_peak_search view; master = controller/correlator/test view.
// Optional runner-up outputs exist only when SFO_PEAK_SEARCH_SECOND_BEST_EN is defined.
interface sfo_peak_search_if #(
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 32,
  parameter int HYP_CNT_WIDTH  = 8
);
  // sweep control and configuration
  logic                      start;
  logic                      abort;
  logic [SFO_INT_WIDTH-1:0]  sfo_start_int;
  logic [SFO_FRAC_WIDTH-1:0] sfo_start_frac;
  logic [SFO_INT_WIDTH-1:0]  sfo_step_int;
  logic [SFO_FRAC_WIDTH-1:0] sfo_step_frac;
  logic [HYP_CNT_WIDTH-1:0]  num_hypotheses;
  // correlator / FFT replay side
  logic [SFO_INT_WIDTH-1:0]  sfo_int_part;
  logic [SFO_FRAC_WIDTH-1:0] sfo_frac_part;
  logic                      correlation_reset;
  logic                      fft_replay_start;
  logic [CORR_WIDTH:0]       correlation_out;
  logic                      correlation_out_valid;
  // status and result
  logic                      busy;
  logic                      done;
  logic                      best_valid;
  logic [SFO_INT_WIDTH-1:0]  best_sfo_int;
  logic [SFO_FRAC_WIDTH-1:0] best_sfo_frac;
  logic [CORR_WIDTH-1:0]     best_corr;
  logic [HYP_CNT_WIDTH-1:0]  best_index;
  logic [HYP_CNT_WIDTH-1:0]  timeout_count;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
  logic [CORR_WIDTH-1:0]     second_corr;
  logic                      second_valid;
  logic [HYP_CNT_WIDTH-1:0]  second_index;
`endif

  modport slave (
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
    output second_corr, second_valid, second_index,
`endif
    input  start, abort, sfo_start_int, sfo_start_frac, sfo_step_int, sfo_step_frac,
           num_hypotheses, correlation_out, correlation_out_valid,
    output sfo_int_part, sfo_frac_part, correlation_reset, fft_replay_start, busy, done,
           best_valid, best_sfo_int, best_sfo_frac, best_corr, best_index, timeout_count
  );

  modport master (
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
    input  second_corr, second_valid, second_index,
`endif
    output start, abort, sfo_start_int, sfo_start_frac, sfo_step_int, sfo_step_frac,
           num_hypotheses, correlation_out, correlation_out_valid,
    input  sfo_int_part, sfo_frac_part, correlation_reset, fft_replay_start, busy, done,
           best_valid, best_sfo_int, best_sfo_frac, best_corr, best_index, timeout_count
  );
endinterface

// File: rtl/sfo_peak_search.sv
// SFO hypothesis sweep: steps the correlator through N hypotheses and keeps the best passing one.
// Latency: LOAD + WAIT(correlator latency, capped at TIMEOUT_CYCLES) + UPDATE/SKIP per hypothesis.
// Backpressure: none; waits on correlation_out_valid level, times out per hypothesis; abort wins.
// Ports: clk, reset (sync, active-high), bus (sfo_peak_search_if.slave: control/config in,
//        hypothesis + correlation_reset/fft_replay_start out, correlator result in, best_* out).
// Optional: SFO_PEAK_SEARCH_SECOND_BEST_EN adds runner-up tracking (second_corr/valid/index).
module sfo_peak_search #(
  parameter int SFO_INT_WIDTH  = 9,
  parameter int SFO_FRAC_WIDTH = 16,
  parameter int CORR_WIDTH     = 32,
  parameter int HYP_CNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              clk,
  input logic              reset,
  sfo_peak_search_if.slave bus
);
  localparam int HYP_WIDTH  = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
  localparam int WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_UPDATE,
    S_SKIP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // sweep configuration and position
  logic [HYP_WIDTH-1:0]     hyp_q;
  logic [HYP_WIDTH-1:0]     step_q;
  logic [HYP_CNT_WIDTH-1:0] num_q;
  logic [HYP_CNT_WIDTH-1:0] k_q;
  logic [WAIT_WIDTH-1:0]    wait_cnt_q;
  logic [CORR_WIDTH:0]      corr_q;

  // result
  logic                     best_valid_q;
  logic [HYP_WIDTH-1:0]     best_hyp_q;
  logic [CORR_WIDTH-1:0]    best_corr_q;
  logic [HYP_CNT_WIDTH-1:0] best_index_q;
  logic [HYP_CNT_WIDTH-1:0] timeout_cnt_q;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
  logic                     second_valid_q;
  logic [CORR_WIDTH-1:0]    second_corr_q;
  logic [HYP_CNT_WIDTH-1:0] second_index_q;
`endif

  // datapath strobes decoded by the FSM
  logic accept, wait_clr, wait_inc, sample, update, skip, advance;
  logic last_hyp;
  logic load_o, busy_o, done_o;

  assign last_hyp = (k_q == num_q - HYP_CNT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    sample   = 1'b0;
    update   = 1'b0;
    skip     = 1'b0;
    advance  = 1'b0;
    load_o   = (state_q == S_LOAD);
    busy_o   = (state_q != S_IDLE);
    done_o   = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          // an empty sweep reports straight away with nothing found
          state_d = (bus.num_hypotheses == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        wait_clr = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the final wait cycle is still taken
        if (bus.correlation_out_valid) begin
          sample  = 1'b1;
          state_d = S_UPDATE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_SKIP;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_UPDATE, S_SKIP: begin
        update = (state_q == S_UPDATE);
        skip   = (state_q == S_SKIP);
        if (last_hyp) begin
          state_d = S_DONE;
        end else begin
          advance = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort freezes the datapath where it stands and drops to IDLE
    if (bus.abort) begin
      state_d  = S_IDLE;
      accept   = 1'b0;
      wait_clr = 1'b0;
      wait_inc = 1'b0;
      sample   = 1'b0;
      update   = 1'b0;
      skip     = 1'b0;
      advance  = 1'b0;
    end
  end

  logic [CORR_WIDTH-1:0] mag;
  logic                  pass, beats_best;
  assign mag        = corr_q[CORR_WIDTH-1:0];
  assign pass       = corr_q[CORR_WIDTH];
  // strict compare: equal magnitudes keep the earlier hypothesis
  assign beats_best = !best_valid_q || (mag > best_corr_q);
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
  logic beats_second;
  assign beats_second = !second_valid_q || (mag > second_corr_q);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hyp_q          <= '0;
      step_q         <= '0;
      num_q          <= '0;
      k_q            <= '0;
      wait_cnt_q     <= '0;
      corr_q         <= '0;
      best_valid_q   <= 1'b0;
      best_hyp_q     <= '0;
      best_corr_q    <= '0;
      best_index_q   <= '0;
      timeout_cnt_q  <= '0;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
      second_valid_q <= 1'b0;
      second_corr_q  <= '0;
      second_index_q <= '0;
`endif
    end else begin
      if (accept) begin
        hyp_q          <= {bus.sfo_start_int, bus.sfo_start_frac};
        step_q         <= {bus.sfo_step_int, bus.sfo_step_frac};
        num_q          <= bus.num_hypotheses;
        k_q            <= '0;
        best_valid_q   <= 1'b0;
        best_hyp_q     <= '0;
        best_corr_q    <= '0;
        best_index_q   <= '0;
        timeout_cnt_q  <= '0;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
        second_valid_q <= 1'b0;
        second_corr_q  <= '0;
        second_index_q <= '0;
`endif
      end

      if (wait_clr) begin
        wait_cnt_q <= '0;
      end else if (wait_inc) begin
        wait_cnt_q <= wait_cnt_q + WAIT_WIDTH'(1);
      end

      if (sample) begin
        corr_q <= bus.correlation_out;
      end

      // hyp_q still holds the hypothesis being scored during UPDATE
      if (update && pass) begin
        if (beats_best) begin
          best_valid_q   <= 1'b1;
          best_hyp_q     <= hyp_q;
          best_corr_q    <= mag;
          best_index_q   <= k_q;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
          // the displaced best becomes the runner-up
          second_valid_q <= best_valid_q;
          second_corr_q  <= best_corr_q;
          second_index_q <= best_index_q;
`endif
        end
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
        else if (beats_second) begin
          second_valid_q <= 1'b1;
          second_corr_q  <= mag;
          second_index_q <= k_q;
        end
`endif
      end

      if (skip && (timeout_cnt_q != '1)) begin
        timeout_cnt_q <= timeout_cnt_q + HYP_CNT_WIDTH'(1);
      end

      // {int,frac} add: frac carries into int, int wraps silently
      if (advance) begin
        k_q   <= k_q + HYP_CNT_WIDTH'(1);
        hyp_q <= hyp_q + step_q;
      end
    end
  end

  assign bus.sfo_int_part      = hyp_q[HYP_WIDTH-1:SFO_FRAC_WIDTH];
  assign bus.sfo_frac_part     = hyp_q[SFO_FRAC_WIDTH-1:0];
  assign bus.correlation_reset = load_o;
  assign bus.fft_replay_start  = load_o;
  assign bus.busy              = busy_o;
  assign bus.done              = done_o;
  assign bus.best_valid        = best_valid_q;
  assign bus.best_sfo_int      = best_hyp_q[HYP_WIDTH-1:SFO_FRAC_WIDTH];
  assign bus.best_sfo_frac     = best_hyp_q[SFO_FRAC_WIDTH-1:0];
  assign bus.best_corr         = best_corr_q;
  assign bus.best_index        = best_index_q;
  assign bus.timeout_count     = timeout_cnt_q;
`ifdef SFO_PEAK_SEARCH_SECOND_BEST_EN
  assign bus.second_valid      = second_valid_q;
  assign bus.second_corr       = second_corr_q;
  assign bus.second_index      = second_index_q;
`endif
endmodule
